// File: rtl/sopc_pio_pkg.sv
// sopc_pio_pkg
// Shared definitions for the debounced input PIO: the Avalon word
// addresses of the register map and the selectable capture-edge types,
// plus a helper that decides whether a settled transition is a captured edge.
package sopc_pio_pkg;

    // Avalon word addresses of the register map
    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_PERIOD = 2'd1,
        ADDR_MASK   = 2'd2,
        ADDR_EDGE   = 2'd3
    } pio_addr_e;

    // Values of the EDGE_TYPE parameter
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // True when a debounced bit settling to new_val counts as a captured edge
    function automatic logic edge_match(input int edge_type, input logic new_val);
        case (edge_type)
            EDGE_RISING:  return new_val;
            EDGE_FALLING: return !new_val;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit
// One input bit of the debounced PIO: a 2-FF synchroniser followed by a
// counter that lets the stable value follow the synchronised input only
// after `period` consecutive differing cycles.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   in_bit       - asynchronous raw input
//   period       - debounce period in clk cycles (0 behaves as 1)
//   stable       - debounced value
//   edge_pulse   - high in the cycle whose clock edge updates stable in the
//                  EDGE_TYPE direction (combinational, consumed at that edge)
module pio_debounce_bit
    import sopc_pio_pkg::*;
#(
    parameter int   CNT_W     = 16,
    parameter int   EDGE_TYPE = EDGE_RISING,
    parameter logic INIT_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic [CNT_W-1:0] period,
    output logic             stable,
    output logic             edge_pulse
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             differ;
    logic             settle;

    // The increment is one bit wider than the counter so the compare against
    // period cannot wrap; settling fires before the counter could overflow,
    // and period 0 settles on the first differing cycle just like period 1.
    always_comb begin
        differ     = (s2 != stable);
        cnt_inc    = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        settle     = differ && (cnt_inc >= {1'b0, period});
        edge_pulse = settle && edge_match(EDGE_TYPE, s2);
    end

    // Synchroniser chain plus debounce counter; any agreeing cycle restarts
    // the count, so glitches shorter than the period are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= INIT_VAL;
            s2     <= INIT_VAL;
            stable <= INIT_VAL;
            cnt    <= '0;
        end else begin
            s1 <= in_bit;
            s2 <= s1;
            if (!differ) begin
                cnt <= '0;
            end else if (settle) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt_inc[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sopc_pio_debounce_in.sv
// sopc_pio_debounce_in
// Debounced push-button/switch input PIO for the Nios II bus. Each input
// bit is synchronised and debounced, settled edges are captured per bit,
// and a masked level interrupt is raised while any enabled capture is set.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   chipselect, address - Avalon slave select and word address
//   write, writedata    - Avalon write strobe and data
//   in_port             - asynchronous raw inputs
//   readdata            - registered read data, one cycle of latency
//   irq                 - level interrupt, active-high
// Register map: 0 stable data (RO), 1 debounce period, 2 irq mask,
// 3 edge capture (write 1 to clear).
module sopc_pio_debounce_in
    import sopc_pio_pkg::*;
#(
    parameter int               WIDTH            = 2,
    parameter int               CNT_W            = 16,
    parameter int               DEBOUNCE_DEFAULT = 50000,
    parameter int               EDGE_TYPE        = EDGE_RISING,
    parameter logic [WIDTH-1:0] INIT_VAL         = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [CNT_W-1:0] period;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_pulse;
    logic             wr_en;
    logic [WIDTH-1:0] edge_clear;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    // Upper writedata bits are don't-care for every register
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .CNT_W     (CNT_W),
            .EDGE_TYPE (EDGE_TYPE),
            .INIT_VAL  (INIT_VAL[i])
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .in_bit     (in_port[i]),
            .period     (period),
            .stable     (stable[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

    // Write decode and the read mux; every register is zero-extended to 32 bits
    always_comb begin
        wr_en      = chipselect && write;
        edge_clear = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        read_mux   = '0;
        case (address)
            ADDR_DATA:   read_mux[WIDTH-1:0] = stable;
            ADDR_PERIOD: read_mux[CNT_W-1:0] = period;
            ADDR_MASK:   read_mux[WIDTH-1:0] = mask;
            ADDR_EDGE:   read_mux[WIDTH-1:0] = edgecapture;
            default:     read_mux = '0;
        endcase
    end

    // Register file, edge capture and interrupt. A capture arriving in the
    // same cycle as a clear of that bit wins, so no edge is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            period      <= CNT_W'(DEBOUNCE_DEFAULT);
            mask        <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            readdata    <= read_mux;
            irq         <= |(edgecapture & mask);
            edgecapture <= (edgecapture & ~edge_clear) | edge_pulse;
            if (wr_en && address == ADDR_PERIOD) begin
                period <= writedata[CNT_W-1:0];
            end
            if (wr_en && address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sopc_pio_debounce_in.sv
// tb_sopc_pio_debounce_in
// Three instances share one stimulus stream: rising-edge capture with
// INIT_VAL 0, falling-edge capture with INIT_VAL 0, and any-edge capture
// with INIT_VAL 4'hF. A reference model predicts readdata/irq for each
// read; a monitor pops and compares one cycle after each read is issued.
module tb_sopc_pio_debounce_in;

    localparam int         NDUT     = 3;
    localparam int         HIST     = 64;
    localparam int         EDGE_T [NDUT] = '{0, 1, 2};
    localparam logic [3:0] INITV  [NDUT] = '{4'h0, 4'h0, 4'hF};

    typedef struct packed {
        logic [1:0]            addr;
        logic [NDUT-1:0][31:0] rd;
        logic [NDUT-1:0]       irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_o [NDUT];
    logic        irq_o [NDUT];

    int vectors = 0;
    int miscompares = 0;

    exp_t exp_q[$];

    // Reference model state (per instance)
    logic [3:0]  m_s1 [NDUT];
    logic [3:0]  m_s2 [NDUT];
    logic [3:0]  m_stable [NDUT];
    logic [3:0]  m_edge [NDUT];
    logic [3:0]  m_mask [NDUT];
    logic [15:0] m_period [NDUT];
    logic [31:0] m_rd [NDUT];
    logic        m_irq [NDUT];
    logic [3:0]  m_hist [NDUT][HIST];
    int          m_hlen [NDUT];

    always #5 clk = ~clk;

    sopc_pio_debounce_in #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_DEFAULT(4), .EDGE_TYPE(0), .INIT_VAL(4'h0)) dut_rise (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_o[0]), .irq(irq_o[0]));

    sopc_pio_debounce_in #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_DEFAULT(4), .EDGE_TYPE(1), .INIT_VAL(4'h0)) dut_fall (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_o[1]), .irq(irq_o[1]));

    sopc_pio_debounce_in #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_DEFAULT(4), .EDGE_TYPE(2), .INIT_VAL(4'hF)) dut_any (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_o[2]), .irq(irq_o[2]));

    // Advance the model by one clock edge using the inputs present at that edge.
    // Debounce rule: a bit settles when the last max(period,1) synchronised
    // samples all disagree with the current stable value.
    task automatic model_step();
        exp_t        e;
        logic [31:0] rd_n;
        logic        irq_n;
        logic [3:0]  stab_n;
        logic [3:0]  set_v;
        logic [3:0]  clr_v;
        logic        all_diff;
        int          p;
        e = '0;
        e.addr = address;
        for (int d = 0; d < NDUT; d++) begin
            if (reset) begin
                m_s1[d] = INITV[d];
                m_s2[d] = INITV[d];
                m_stable[d] = INITV[d];
                m_edge[d] = 4'h0;
                m_mask[d] = 4'h0;
                m_period[d] = 16'd4;
                m_rd[d] = 32'h0;
                m_irq[d] = 1'b0;
                m_hlen[d] = 0;
            end else begin
                case (address)
                    2'd0:    rd_n = {28'h0, m_stable[d]};
                    2'd1:    rd_n = {16'h0, m_period[d]};
                    2'd2:    rd_n = {28'h0, m_mask[d]};
                    default: rd_n = {28'h0, m_edge[d]};
                endcase
                irq_n = |(m_edge[d] & m_mask[d]);
                for (int k = HIST - 1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                m_hist[d][0] = m_s2[d];
                if (m_hlen[d] < HIST) m_hlen[d]++;
                p = (m_period[d] == 16'd0) ? 1 : int'(m_period[d]);
                stab_n = m_stable[d];
                set_v = 4'h0;
                for (int i = 0; i < 4; i++) begin
                    if (m_hlen[d] >= p) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < p; k++)
                            if (m_hist[d][k][i] == m_stable[d][i]) all_diff = 1'b0;
                        if (all_diff) begin
                            stab_n[i] = ~m_stable[d][i];
                            if (EDGE_T[d] == 2 || (EDGE_T[d] == 0 && stab_n[i]) || (EDGE_T[d] == 1 && !stab_n[i]))
                                set_v[i] = 1'b1;
                        end
                    end
                end
                clr_v = (chipselect && write && address == 2'd3) ? writedata[3:0] : 4'h0;
                m_edge[d] = (m_edge[d] & ~clr_v) | set_v;
                if (chipselect && write && address == 2'd1) m_period[d] = writedata[15:0];
                if (chipselect && write && address == 2'd2) m_mask[d] = writedata[3:0];
                m_s2[d] = m_s1[d];
                m_s1[d] = in_port;
                m_stable[d] = stab_n;
                m_rd[d] = rd_n;
                m_irq[d] = irq_n;
            end
            e.rd[d] = m_rd[d];
            e.irq[d] = m_irq[d];
        end
        if (chipselect && !write && !reset) exp_q.push_back(e);
    endtask

    // Drive one bus cycle, let the model see the same edge, then move off it
    task automatic applyStimulus(input logic cs, input logic we, input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs;
        write = we;
        address = a;
        writedata = wd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic doWrite(input logic [1:0] a, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b1, a, wd);
    endtask

    // n read cycles at address a; a < 0 picks a random address each cycle
    task automatic idle(input int n, input int a);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b1, 1'b0, (a < 0) ? 2'($urandom_range(0, 3)) : 2'(a), 32'h0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
        reset = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (rd_o[d] !== e.rd[d]) begin
                miscompares++;
                $display("[TB] FAIL readdata dut%0d addr%0d: got %h, want %h", d, e.addr, rd_o[d], e.rd[d]);
            end
            vectors++;
            if (irq_o[d] !== e.irq[d]) begin
                miscompares++;
                $display("[TB] FAIL irq dut%0d: got %b, want %b", d, irq_o[d], e.irq[d]);
            end
        end
    endtask

    // Monitor: a read issued at one edge presents its data by the next negedge
    logic pend = 1'b0;
    always @(posedge clk) pend <= chipselect && !write && !reset;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard: got read data, want a queued expectation");
            end else begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] wd;
        logic [1:0]  wa;
        reset = 1'b1;
        chipselect = 1'b0;
        address = 2'd0;
        write = 1'b0;
        writedata = 32'h0;
        in_port = 4'h0;
        $display("[TB] start");

        // Reset values of every register
        doReset();
        for (int a = 0; a < 4; a++) idle(1, a);

        // Bounce rejection then a clean rise on bit 0
        for (int r = 0; r < 3; r++) begin
            in_port[0] = 1'b1;
            idle(3, 0);
            in_port[0] = 1'b0;
            idle(3, 0);
        end
        idle(1, 3);
        in_port[0] = 1'b1;
        idle(10, 0);
        idle(1, 3);

        // Masked capture raises irq, W1C drops it
        in_port[0] = 1'b0;
        idle(10, 0);
        doWrite(2'd3, 32'hF);
        doWrite(2'd2, 32'h1);
        in_port[0] = 1'b1;
        idle(10, 3);
        doWrite(2'd3, 32'h1);
        idle(3, 3);

        // Clear of bit 1 on the very edge it gets captured
        in_port[1] = 1'b1;
        idle(5, 0);
        doWrite(2'd3, 32'h2);
        idle(3, 3);

        // Period 0 behaves as 1
        doWrite(2'd1, 32'h0);
        in_port[2] = 1'b1;
        idle(4, 0);
        in_port[2] = 1'b0;
        idle(4, 0);

        // Shrinking the period mid-count
        doWrite(2'd1, 32'h8);
        in_port[3] = 1'b1;
        idle(5, 0);
        doWrite(2'd1, 32'h2);
        idle(4, 0);
        idle(1, 1);

        // Masked-off captures, then enabling the mask raises irq
        doWrite(2'd1, 32'h4);
        doWrite(2'd3, 32'hF);
        doWrite(2'd2, 32'h0);
        in_port[2] = 1'b1;
        idle(8, 3);
        in_port[2] = 1'b0;
        idle(8, 3);
        doWrite(2'd2, 32'h4);
        idle(3, 3);

        // Randomised traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    in_port = in_port ^ 4'($urandom_range(0, 15));
                    idle($urandom_range(1, 8), -1);
                end
                6, 7, 8: begin
                    wa = 2'($urandom_range(0, 3));
                    wd = $urandom();
                    if (wa == 2'd1) wd = {wd[31:16], 16'($urandom_range(0, 7))};
                    doWrite(wa, wd);
                end
                default: begin
                    if ($urandom_range(0, 9) == 0) doReset();
                    else applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
                end
            endcase
        end

        idle(2, 0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
